seq_game_core: RTL

//   Parametrised memory-game core: generates a pseudo-random sequence, plays it back on N_BTN lamps, then checks the

---
 rtl/seq_game_pkg.sv | 36 +++
 rtl/seq_game_if.sv | 34 +++
 rtl/seq_lfsr.sv | 34 +++
 rtl/seq_game_core.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/seq_game_pkg.sv
// Shared types and helpers for the memory-game core.
//   state_t     : FSM state encoding (3 bits)
//   LFSR_POLY   : Galois feedback mask, x^16+x^14+x^13+x^11
//   clog2       : ceiling log2 for width derivation
//   onehot8     : index -> one-hot (8-bit wide, callers truncate)
//   is_onehot8  : exactly-one-bit-set test
package seq_game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GEN,
    ST_SHOW_ON,
    ST_SHOW_OFF,
    ST_WAIT_USER,
    ST_WIN,
    ST_LOSE
  } state_t;

  localparam logic [15:0] LFSR_POLY = 16'hB400;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic logic [7:0] onehot8(input logic [2:0] idx);
    return 8'd1 << idx;
  endfunction

  function automatic logic is_onehot8(input logic [7:0] v);
    return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
  endfunction

endpackage

// File: rtl/seq_game_if.sv
// Control/status bundle between the game core and its surroundings.
//   master : tick/start/seed/rounds_goal/btn_pulse out, status in
//   slave  : the game core side (inputs above, lamp/round/score/flags out)
interface seq_game_if import seq_game_pkg::*; #(
  parameter int N_BTN   = 4,
  parameter int DEPTH   = 16,
  parameter int SCORE_W = 8
) ();
  localparam int RW = clog2(DEPTH + 1);

  logic               tick;
  logic               start;
  logic [15:0]        seed;
  logic [RW-1:0]      rounds_goal;
  logic [N_BTN-1:0]   btn_pulse;
  logic [N_BTN-1:0]   lamp;
  logic [RW-1:0]      round;
  logic [SCORE_W-1:0] score;
  logic               busy;
  logic               user_turn;
  logic               win;
  logic               lose;
  logic               end_time;

  modport master (
    output tick, start, seed, rounds_goal, btn_pulse,
    input  lamp, round, score, busy, user_turn, win, lose, end_time
  );

  modport slave (
    input  tick, start, seed, rounds_goal, btn_pulse,
    output lamp, round, score, busy, user_turn, win, lose, end_time
  );
endinterface

// File: rtl/seq_lfsr.sv
// 16-bit right-shifting Galois LFSR.
//   clk, rst_n : clock, asynchronous active-low reset
//   load_i     : load seed_i (takes priority over step_i)
//   step_i     : advance one step
//   seed_i     : value to load (caller guarantees non-zero)
//   bits_o     : low OUT_W bits of the current state
module seq_lfsr import seq_game_pkg::*; #(
  parameter int OUT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [15:0]      seed_i,
  output logic [OUT_W-1:0] bits_o
);
  logic [15:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = seed_i;
    end else if (step_i) begin
      state_d = (state_q >> 1) ^ (state_q[0] ? LFSR_POLY : 16'h0000);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= 16'h0001;
    else        state_q <= state_d;
  end

  assign bits_o = state_q[OUT_W-1:0];
endmodule

// File: rtl/seq_game_core.sv
// Memory-game core: extends a pseudo-random sequence by one element per round,
// plays it on the lamps (one tick on, one tick off per element), then checks
// the player's presses, with wrong/multi press and inactivity-timeout losses.
//   clock_50 : system clock (rising edge)
//   reset    : asynchronous active-low reset
//   bus      : seq_game_if.slave (tick/start/seed/rounds_goal/btn_pulse in;
//              lamp/round/score/busy/user_turn/win/lose/end_time out, all registered)
module seq_game_core import seq_game_pkg::*; #(
  parameter int N_BTN         = 4,
  parameter int DEPTH         = 16,
  parameter int TIMEOUT_TICKS = 10,
  parameter int SCORE_W       = 8
) (
  input logic       clock_50,
  input logic       reset,
  seq_game_if.slave bus
);
  localparam int SEQ_W = clog2(N_BTN);
  localparam int RW    = clog2(DEPTH + 1);
  localparam int IW    = clog2(DEPTH);
  localparam int TW    = clog2(TIMEOUT_TICKS + 1);

  state_t             state_q, state_d;
  logic [IW-1:0]      play_idx_q, play_idx_d, in_idx_q, in_idx_d;
  logic [RW-1:0]      round_q, round_d, goal_q, goal_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [N_BTN-1:0]   lamp_q, lamp_d;
  logic               busy_q, busy_d, user_turn_q, user_turn_d;
  logic               win_q, win_d, lose_q, lose_d, end_time_q, end_time_d;

  logic [SEQ_W-1:0]   seq_mem [DEPTH];
  logic [SEQ_W-1:0]   lfsr_bits, show_elem;
  logic               lfsr_load, lfsr_step, seq_we;
  logic [15:0]        seed_eff;
  logic [IW-1:0]      last_idx;

  assign seed_eff = (bus.seed == 16'h0000) ? 16'h0001 : bus.seed;
  assign last_idx = IW'(round_q - RW'(1));

  seq_lfsr #(.OUT_W(SEQ_W)) u_lfsr (
    .clk    (clock_50),
    .rst_n  (reset),
    .load_i (lfsr_load),
    .step_i (lfsr_step),
    .seed_i (seed_eff),
    .bits_o (lfsr_bits)
  );

  // Sequence store; contents are meaningless until written by GEN.
  always_ff @(posedge clock_50) begin
    if (seq_we) seq_mem[last_idx] <= lfsr_bits;
  end

  always_comb begin
    state_d     = state_q;
    play_idx_d  = play_idx_q;
    in_idx_d    = in_idx_q;
    round_d     = round_q;
    goal_d      = goal_q;
    timer_d     = timer_q;
    score_d     = score_q;
    end_time_d  = end_time_q;
    lfsr_load   = 1'b0;
    lfsr_step   = 1'b0;
    seq_we      = 1'b0;
    lamp_d      = '0;
    show_elem   = '0;

    case (state_q)
      ST_IDLE, ST_WIN, ST_LOSE: begin
        if (bus.start) begin
          lfsr_load  = 1'b1;
          round_d    = RW'(1);
          score_d    = '0;
          end_time_d = 1'b0;
          timer_d    = '0;
          in_idx_d   = '0;
          play_idx_d = '0;
          goal_d     = (bus.rounds_goal == '0 || bus.rounds_goal > RW'(DEPTH))
                       ? RW'(DEPTH) : bus.rounds_goal;
          state_d    = ST_GEN;
        end
      end
      ST_GEN: begin
        seq_we     = 1'b1;
        lfsr_step  = 1'b1;
        play_idx_d = '0;
        state_d    = ST_SHOW_ON;
      end
      ST_SHOW_ON: begin
        if (bus.tick) state_d = ST_SHOW_OFF;
      end
      ST_SHOW_OFF: begin
        if (bus.tick) begin
          if (play_idx_q == last_idx) begin
            in_idx_d = '0;
            timer_d  = '0;
            state_d  = ST_WAIT_USER;
          end else begin
            play_idx_d = play_idx_q + IW'(1);
            state_d    = ST_SHOW_ON;
          end
        end
      end
      ST_WAIT_USER: begin
        // A press wins over a same-cycle tick: the tick is simply not counted.
        if (bus.btn_pulse != '0) begin
          if (!is_onehot8(8'(bus.btn_pulse)) ||
              8'(bus.btn_pulse) != onehot8(3'(seq_mem[in_idx_q]))) begin
            end_time_d = 1'b0;
            state_d    = ST_LOSE;
          end else begin
            if (score_q != {SCORE_W{1'b1}}) score_d = score_q + SCORE_W'(1);
            timer_d = '0;
            if (in_idx_q == last_idx) begin
              if (round_q == goal_q) begin
                state_d = ST_WIN;
              end else begin
                round_d = round_q + RW'(1);
                state_d = ST_GEN;
              end
            end else begin
              in_idx_d = in_idx_q + IW'(1);
            end
          end
        end else if (bus.tick) begin
          if (timer_q == TW'(TIMEOUT_TICKS - 1)) begin
            end_time_d = 1'b1;
            state_d    = ST_LOSE;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered from the next state. On GEN -> SHOW_ON in round 1
    // the element is still being written, so it is taken straight from the LFSR.
    if (state_d == ST_SHOW_ON) begin
      show_elem = (state_q == ST_GEN && last_idx == '0) ? lfsr_bits : seq_mem[play_idx_d];
      lamp_d    = N_BTN'(onehot8(3'(show_elem)));
    end
    busy_d      = !(state_d inside {ST_IDLE, ST_WIN, ST_LOSE});
    user_turn_d = (state_d == ST_WAIT_USER);
    win_d       = (state_d == ST_WIN);
    lose_d      = (state_d == ST_LOSE);
  end

  always_ff @(posedge clock_50 or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      play_idx_q  <= '0;
      in_idx_q    <= '0;
      round_q     <= '0;
      goal_q      <= '0;
      timer_q     <= '0;
      score_q     <= '0;
      lamp_q      <= '0;
      busy_q      <= 1'b0;
      user_turn_q <= 1'b0;
      win_q       <= 1'b0;
      lose_q      <= 1'b0;
      end_time_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      play_idx_q  <= play_idx_d;
      in_idx_q    <= in_idx_d;
      round_q     <= round_d;
      goal_q      <= goal_d;
      timer_q     <= timer_d;
      score_q     <= score_d;
      lamp_q      <= lamp_d;
      busy_q      <= busy_d;
      user_turn_q <= user_turn_d;
      win_q       <= win_d;
      lose_q      <= lose_d;
      end_time_q  <= end_time_d;
    end
  end

  assign bus.lamp      = lamp_q;
  assign bus.round     = round_q;
  assign bus.score     = score_q;
  assign bus.busy      = busy_q;
  assign bus.user_turn = user_turn_q;
  assign bus.win       = win_q;
  assign bus.lose      = lose_q;
  assign bus.end_time  = end_time_q;
endmodule
